// File: rtl/rng_pkg.sv
// Shared definitions for the RNG card-dealing path: FSM state encoding,
// default deck geometry and the card index type used by the RNG datapath.
package rng_pkg;

  localparam int CARD_W_DEF    = 6;
  localparam int DECK_SIZE_DEF = 52;

  typedef logic [CARD_W_DEF-1:0] card_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_CHECK = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rng_deck_tracker.sv
// Deck bookkeeping: one mask bit per dealt card plus a registered count of
// the cards still available. Out-of-range queries report "taken".
module rng_deck_tracker
  import rng_pkg::*;
#(
  parameter int CARD_W    = CARD_W_DEF,
  parameter int DECK_SIZE = DECK_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              clear,
  input  logic              set,
  input  logic [CARD_W-1:0] set_idx,
  input  logic [CARD_W-1:0] query_idx,
  output logic              taken,
  output logic [5:0]        cards_left,
  output logic              deck_empty
);

  logic [DECK_SIZE-1:0] mask;
  logic                 query_in_range;
  logic                 set_in_range;

  assign query_in_range = int'(query_idx) < DECK_SIZE;
  assign set_in_range   = int'(set_idx) < DECK_SIZE;
  assign taken          = query_in_range ? mask[query_idx] : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      mask       <= '0;
      cards_left <= 6'(DECK_SIZE);
      deck_empty <= 1'b0;
    end else if (clear) begin
      mask       <= '0;
      cards_left <= 6'(DECK_SIZE);
      deck_empty <= 1'b0;
    end else if (set && set_in_range && !mask[set_idx] && cards_left != 6'd0) begin
      // the count saturates at zero so it can never wrap
      mask[set_idx] <= 1'b1;
      cards_left    <= cards_left - 6'd1;
      deck_empty    <= (cards_left == 6'd1);
    end
  end

endmodule

// File: rtl/rng_card_dealer.sv
// Requests random values from the RNG, turns them into distinct cards drawn
// without replacement and hands them to the game logic over valid/ready.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for an acceptable deal_start_i; deck refill allowed
// REQ      | req_card_o high, waiting for rng_valid_i (bounded by TIMEOUT)
// CHECK    | reject out-of-range/duplicate value or claim the card
// OUT      | card_valid_o held until card_ready_i
// DONE     | one-cycle done_o pulse, then IDLE
module rng_card_dealer
  import rng_pkg::*;
#(
  parameter int CARD_W    = CARD_W_DEF,
  parameter int DECK_SIZE = DECK_SIZE_DEF,
  parameter int HAND_MAX  = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_dl_i,
  input  logic              rst_dl_i,
  input  logic              deal_start_i,
  input  logic [3:0]        hand_size_i,
  input  logic              new_deck_i,
  output logic              req_card_o,
  input  logic              rng_valid_i,
  input  logic [CARD_W-1:0] rng_data_i,
  output logic [CARD_W-1:0] card_o,
  output logic              card_valid_o,
  input  logic              card_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              deck_empty_o,
  output logic              timeout_err_o,
  output logic [5:0]        cards_left_o
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state;
  logic [3:0]        hand_q;
  logic [3:0]        dealt_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [CARD_W-1:0] rng_q;

  logic              deck_clear;
  logic              deck_set;
  logic              taken;
  logic [5:0]        eff_left;
  logic              start_ok;

  assign deck_clear = (state == ST_IDLE) && new_deck_i;
  assign deck_set   = (state == ST_CHECK) && !taken;

  // a same-cycle refill is applied before the start is judged
  always_comb begin
    eff_left = new_deck_i ? 6'(DECK_SIZE) : cards_left_o;
    start_ok = (state == ST_IDLE) && deal_start_i &&
               (hand_size_i != 4'd0) && (hand_size_i <= 4'(HAND_MAX)) &&
               ({2'b00, hand_size_i} <= eff_left);
  end

  rng_deck_tracker #(
    .CARD_W    (CARD_W),
    .DECK_SIZE (DECK_SIZE)
  ) u_deck (
    .clk        (clk_dl_i),
    .rst_b      (rst_dl_i),
    .clear      (deck_clear),
    .set        (deck_set),
    .set_idx    (rng_q),
    .query_idx  (rng_q),
    .taken      (taken),
    .cards_left (cards_left_o),
    .deck_empty (deck_empty_o)
  );

  always_ff @(posedge clk_dl_i) begin
    if (!rst_dl_i) begin
      state         <= ST_IDLE;
      req_card_o    <= 1'b0;
      card_valid_o  <= 1'b0;
      card_o        <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      timeout_err_o <= 1'b0;
      hand_q        <= 4'd0;
      dealt_q       <= 4'd0;
      tmo_cnt       <= '0;
      rng_q         <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            hand_q        <= hand_size_i;
            dealt_q       <= 4'd0;
            timeout_err_o <= 1'b0;
            tmo_cnt       <= '0;
            req_card_o    <= 1'b1;
            busy_o        <= 1'b1;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rng_valid_i) begin
            rng_q      <= rng_data_i;
            req_card_o <= 1'b0;
            state      <= ST_CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            // abort keeps already-dealt cards out of the deck
            req_card_o    <= 1'b0;
            busy_o        <= 1'b0;
            timeout_err_o <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (taken) begin
            tmo_cnt    <= '0;
            req_card_o <= 1'b1;
            state      <= ST_REQ;
          end else begin
            card_o       <= rng_q;
            card_valid_o <= 1'b1;
            state        <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (card_ready_i) begin
            card_valid_o <= 1'b0;
            dealt_q      <= dealt_q + 4'd1;
            if (dealt_q + 4'd1 == hand_q) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              tmo_cnt    <= '0;
              req_card_o <= 1'b1;
              state      <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          req_card_o   <= 1'b0;
          card_valid_o <= 1'b0;
          busy_o       <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
